// File: rtl/mod_exp_seq_if.sv
// rtl/mod_exp_seq_if.sv - operand/product bus between mod_exp_seq and the Montgomery multiplier
interface mod_exp_seq_if #(
  parameter int W = 192
);
  logic [W-1:0] mm_x;
  logic [W-1:0] mm_y;
  logic         mm_start;
  logic [W-1:0] mm_z;
  logic         mm_done;

  modport master (output mm_x, mm_y, mm_start, input mm_z, mm_done);
  modport slave  (input mm_x, mm_y, mm_start, output mm_z, mm_done);
endinterface

// File: rtl/mod_exp_seq.sv
// rtl/mod_exp_seq.sv - left-to-right square-and-multiply sequencer for a Montgomery multiplier
// MODEXP_FROM_MONT_EN adds a final multiply-by-1 (CONV) so the result leaves the Montgomery domain.
module mod_exp_seq #(
  parameter int W   = 192,
  parameter int E_W = 192
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  logic [W-1:0]   base_in_i,
  input  logic [W-1:0]   one_in_i,
  input  logic [E_W-1:0] exp_in_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [W-1:0]   result_o,
  mod_exp_seq_if.master  mm
);
  localparam int I_W = $clog2(E_W);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SQR, S_MUL, S_GAP, S_CONV, S_FIN
  } state_t;

`ifdef MODEXP_FROM_MONT_EN
  localparam state_t       S_TAIL   = S_CONV;
  localparam logic [W-1:0] MONT_ONE = {{(W-1){1'b0}}, 1'b1};
`else
  localparam state_t       S_TAIL   = S_FIN;
`endif

  state_t         state_q, state_d;
  logic [E_W-1:0] e_q, e_d;
  logic [I_W-1:0] i_q, i_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   result_q, result_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           mm_start_q, mm_start_d;
  logic [W-1:0]   mm_x_q, mm_x_d;
  logic [W-1:0]   mm_y_q, mm_y_d;
  logic [E_W-1:0] e_shift;
  logic           bits_left;

  assign e_shift   = {e_q[E_W-2:0], 1'b0};
  assign bits_left = (i_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      e_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      base_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mm_start_q <= 1'b0;
      mm_x_q     <= '0;
      mm_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      i_q        <= i_d;
      acc_q      <= acc_d;
      base_q     <= base_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      mm_start_q <= mm_start_d;
      mm_x_q     <= mm_x_d;
      mm_y_q     <= mm_y_d;
    end
  end

  // Product states spend their first cycle with mm_start low to load operands,
  // which also provides the mandatory low cycle between SQR and MUL.
  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    i_d        = i_q;
    acc_d      = acc_q;
    base_d     = base_q;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q & ~done_q;
    mm_start_d = mm_start_q;
    mm_x_d     = mm_x_q;
    mm_y_d     = mm_y_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !busy_q) begin
          base_d = base_in_i;
          e_d    = exp_in_i;
          i_d    = I_W'(E_W - 1);
          busy_d = 1'b1;
          if (exp_in_i == '0) begin
            acc_d   = one_in_i;
            state_d = S_TAIL;
          end else begin
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        e_d = e_shift;
        if (!e_q[E_W-1]) begin
          i_d = i_q - I_W'(1);
        end else begin
          acc_d   = base_q;
          state_d = bits_left ? S_SQR : S_TAIL;
        end
      end
      S_SQR: begin
        if (!mm_start_q) begin
          mm_start_d = 1'b1;
          mm_x_d     = acc_q;
          mm_y_d     = acc_q;
        end else if (mm.mm_done) begin
          mm_start_d = 1'b0;
          acc_d      = mm.mm_z;
          if (e_q[E_W-1]) begin
            state_d = S_MUL;
          end else begin
            e_d     = e_shift;
            i_d     = i_q - I_W'(1);
            state_d = S_GAP;
          end
        end
      end
      S_MUL: begin
        if (!mm_start_q) begin
          mm_start_d = 1'b1;
          mm_x_d     = acc_q;
          mm_y_d     = base_q;
        end else if (mm.mm_done) begin
          mm_start_d = 1'b0;
          acc_d      = mm.mm_z;
          e_d        = e_shift;
          i_d        = i_q - I_W'(1);
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        state_d = bits_left ? S_SQR : S_TAIL;
      end
`ifdef MODEXP_FROM_MONT_EN
      S_CONV: begin
        if (!mm_start_q) begin
          mm_start_d = 1'b1;
          mm_x_d     = acc_q;
          mm_y_d     = MONT_ONE;
        end else if (mm.mm_done) begin
          mm_start_d = 1'b0;
          acc_d      = mm.mm_z;
          state_d    = S_FIN;
        end
      end
`endif
      S_FIN: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign mm.mm_start = mm_start_q;
  assign mm.mm_x     = mm_x_q;
  assign mm.mm_y     = mm_y_q;
endmodule
